// File: rtl/spectrum_framer_if.sv
// rtl/spectrum_framer_if.sv - bin power output stream with valid/ready handshake
interface spectrum_framer_if #(
   parameter int PW = 36,
   parameter int BW = 8
);
   logic          o_bin_valid;
   logic          i_bin_ready;
   logic [PW-1:0] o_bin_power;
   logic [BW-1:0] o_bin_index;
   logic          o_frame_last;

   modport master (
      output o_bin_valid,
      output o_bin_power,
      output o_bin_index,
      output o_frame_last,
      input  i_bin_ready
   );

   modport slave (
      input  o_bin_valid,
      input  o_bin_power,
      input  o_bin_index,
      input  o_frame_last,
      output i_bin_ready
   );
endinterface

// File: rtl/spectrum_framer.sv
// rtl/spectrum_framer.sv - captures bins 0..N/2 of an FFT frame as power and streams them out
module spectrum_framer #(
   parameter int OW       = 18,
   parameter int FFT_SIZE = 256
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_ce,
   input  logic [2*OW-1:0]      i_fft_result,
   input  logic                 i_fft_sync,
   spectrum_framer_if.master    bin,
   output logic                 o_overrun,
   output logic [7:0]           o_drop_count
);
   localparam int NB = FFT_SIZE/2 + 1;
   localparam int PW = 2*OW;
   localparam int BW = $clog2(NB);
   localparam logic [BW-1:0] LAST_IDX = BW'(NB - 1);

   typedef enum logic [1:0] {IDLE, CAPTURE, READOUT} state_t;

   state_t        state_q, state_d;
   logic [BW-1:0] wr_idx_q, wr_idx_d;
   logic          pipe_vld_q, pipe_vld_d;
   logic [BW-1:0] pipe_idx_q, pipe_idx_d;
   logic          pipe_last_q, pipe_last_d;
   logic [PW-1:0] pipe_pow_q, pipe_pow_d;
   logic          start_q, start_d;
   logic          valid_q, valid_d;
   logic [PW-1:0] power_q, power_d;
   logic [BW-1:0] index_q, index_d;
   logic          last_q, last_d;
   logic          overrun_q, overrun_d;
   logic [7:0]    drop_q, drop_d;

   logic [PW-1:0] mem [NB];

   logic signed [OW-1:0] re, im;
   logic signed [PW-1:0] re_x, im_x;
   logic [PW-1:0]        power_in;
   logic                 sof;
   logic [BW-1:0]        next_idx;

   // Squares are non-negative and each fits PW signed; their sum needs the full unsigned range.
   assign re       = i_fft_result[2*OW-1:OW];
   assign im       = i_fft_result[OW-1:0];
   assign re_x     = PW'(re);
   assign im_x     = PW'(im);
   assign power_in = $unsigned(re_x * re_x) + $unsigned(im_x * im_x);
   assign sof      = i_ce & i_fft_sync;
   assign next_idx = index_q + 1'b1;

   always_comb begin
      state_d     = state_q;
      wr_idx_d    = wr_idx_q;
      pipe_vld_d  = 1'b0;
      pipe_idx_d  = pipe_idx_q;
      pipe_last_d = 1'b0;
      pipe_pow_d  = pipe_pow_q;
      start_d     = pipe_vld_q & pipe_last_q;
      valid_d     = valid_q;
      power_d     = power_q;
      index_d     = index_q;
      last_d      = last_q;
      overrun_d   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (sof) begin
               pipe_vld_d = 1'b1;
               pipe_idx_d = '0;
               pipe_pow_d = power_in;
               wr_idx_d   = BW'(1);
               state_d    = CAPTURE;
            end
         end
         CAPTURE: begin
            if (sof) begin
               overrun_d  = 1'b1;
               pipe_vld_d = 1'b1;
               pipe_idx_d = '0;
               pipe_pow_d = power_in;
               wr_idx_d   = BW'(1);
            end else if (i_ce) begin
               pipe_vld_d  = 1'b1;
               pipe_idx_d  = wr_idx_q;
               pipe_pow_d  = power_in;
               pipe_last_d = (wr_idx_q == LAST_IDX);
               if (wr_idx_q == LAST_IDX) begin
                  state_d = READOUT;
               end else begin
                  wr_idx_d = wr_idx_q + 1'b1;
               end
            end
         end
         READOUT: begin
            // New frames are dropped here; the buffer is owned by the readout until it finishes.
            overrun_d = sof;
            if (start_q) begin
               valid_d = 1'b1;
               index_d = '0;
               power_d = mem[0];
               last_d  = 1'b0;
            end else if (valid_q && bin.i_bin_ready) begin
               if (index_q == LAST_IDX) begin
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  state_d = IDLE;
               end else begin
                  index_d = next_idx;
                  power_d = mem[next_idx];
                  last_d  = (next_idx == LAST_IDX);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      drop_d = (overrun_d && drop_q != 8'hFF) ? drop_q + 1'b1 : drop_q;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q     <= IDLE;
         wr_idx_q    <= '0;
         pipe_vld_q  <= 1'b0;
         pipe_idx_q  <= '0;
         pipe_last_q <= 1'b0;
         pipe_pow_q  <= '0;
         start_q     <= 1'b0;
         valid_q     <= 1'b0;
         power_q     <= '0;
         index_q     <= '0;
         last_q      <= 1'b0;
         overrun_q   <= 1'b0;
         drop_q      <= '0;
      end else begin
         state_q     <= state_d;
         wr_idx_q    <= wr_idx_d;
         pipe_vld_q  <= pipe_vld_d;
         pipe_idx_q  <= pipe_idx_d;
         pipe_last_q <= pipe_last_d;
         pipe_pow_q  <= pipe_pow_d;
         start_q     <= start_d;
         valid_q     <= valid_d;
         power_q     <= power_d;
         index_q     <= index_d;
         last_q      <= last_d;
         overrun_q   <= overrun_d;
         drop_q      <= drop_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (pipe_vld_q) begin
         mem[pipe_idx_q] <= pipe_pow_q;
      end
   end

   assign bin.o_bin_valid  = valid_q;
   assign bin.o_bin_power  = power_q;
   assign bin.o_bin_index  = index_q;
   assign bin.o_frame_last = last_q;
   assign o_overrun        = overrun_q;
   assign o_drop_count     = drop_q;
endmodule

// File: tb/tb_spectrum_framer.sv
// tb/tb_spectrum_framer.sv - scoreboard bench for spectrum_framer with random data and backpressure
module tb_spectrum_framer;
   localparam int OW       = 18;
   localparam int FFT_SIZE = 16;
   localparam int NB       = FFT_SIZE/2 + 1;
   localparam int PW       = 2*OW;
   localparam int BW       = $clog2(NB);

   logic            i_clk = 1'b0;
   logic            i_reset = 1'b1;
   logic            i_ce = 1'b0;
   logic            i_fft_sync = 1'b0;
   logic [2*OW-1:0] i_fft_result = '0;
   logic            o_overrun;
   logic [7:0]      o_drop_count;

   spectrum_framer_if #(.PW(PW), .BW(BW)) bin_if ();

   spectrum_framer #(.OW(OW), .FFT_SIZE(FFT_SIZE)) dut (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_ce         (i_ce),
      .i_fft_result (i_fft_result),
      .i_fft_sync   (i_fft_sync),
      .bin          (bin_if),
      .o_overrun    (o_overrun),
      .o_drop_count (o_drop_count)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      longint unsigned pw;
      int              idx;
      bit              last;
   } beat_t;

   beat_t exp_q[$];
   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int rmode = 0;
   int rcnt = 0;
   int beats = 0;
   int ovr_cycles = 0;
   int first_valid_cyc = -1;
   int last_bin_cyc = 0;
   int xfer0_cyc = 0;
   int xferl_cyc = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      $display("FAIL %s at cycle %0d", name, cyc);
   endtask

   function automatic longint unsigned power_of(input int re, input int im);
      return longint'(re) * longint'(re) + longint'(im) * longint'(im);
   endfunction

   always @(posedge i_clk) cyc <= cyc + 1;

   // 0: always ready, 1: pattern 1,0,0, 2: random, 3: never, 4: stall on index 5
   always @(posedge i_clk) begin
      #1;
      case (rmode)
         0: bin_if.i_bin_ready = 1'b1;
         1: bin_if.i_bin_ready = (rcnt % 3 == 0);
         2: bin_if.i_bin_ready = 1'($urandom_range(0, 1));
         3: bin_if.i_bin_ready = 1'b0;
         default: bin_if.i_bin_ready = !(bin_if.o_bin_valid && bin_if.o_bin_index == BW'(5));
      endcase
      rcnt++;
   end

   logic          prev_stall = 1'b0;
   logic          prev_valid = 1'b0;
   logic [PW-1:0] prev_power;
   logic [BW-1:0] prev_index;
   logic          prev_last;

   always @(negedge i_clk) begin
      if (i_reset) begin
         prev_stall = 1'b0;
         prev_valid = 1'b0;
      end else begin
         beat_t e;
         if (o_overrun) ovr_cycles++;
         if (prev_stall) begin
            check("hold_valid", 64'(bin_if.o_bin_valid), 64'(1));
            check("hold_power", 64'(bin_if.o_bin_power), 64'(prev_power));
            check("hold_index", 64'(bin_if.o_bin_index), 64'(prev_index));
            check("hold_last", 64'(bin_if.o_frame_last), 64'(prev_last));
         end
         if (bin_if.o_bin_valid && !prev_valid) first_valid_cyc = cyc;
         if (bin_if.o_bin_valid && bin_if.i_bin_ready) begin
            if (exp_q.size() == 0) begin
               fail_now("unexpected_beat");
            end else begin
               e = exp_q.pop_front();
               check("beat_power", 64'(bin_if.o_bin_power), 64'(e.pw));
               check("beat_index", 64'(bin_if.o_bin_index), 64'(e.idx));
               check("beat_last", 64'(bin_if.o_frame_last), 64'(e.last));
               if (e.idx == 0) xfer0_cyc = cyc;
               if (e.last) xferl_cyc = cyc;
               beats++;
            end
         end
         prev_stall = bin_if.o_bin_valid && !bin_if.i_bin_ready;
         prev_valid = bin_if.o_bin_valid;
         prev_power = bin_if.o_bin_power;
         prev_index = bin_if.o_bin_index;
         prev_last  = bin_if.o_frame_last;
      end
   end

   // kind 0: re=k, im=-k; kind 1: both at most-negative value; kind 2: random
   task automatic send_frame(input int nbins, input int kind, input bit push);
      for (int k = 0; k < nbins; k++) begin
         int re, im;
         logic [OW-1:0] rb, ib;
         beat_t b;
         case (kind)
            0: begin re = k; im = -k; end
            1: begin re = -131072; im = -131072; end
            default: begin
               re = int'($urandom_range(0, 262143)) - 131072;
               im = int'($urandom_range(0, 262143)) - 131072;
            end
         endcase
         rb = re[OW-1:0];
         ib = im[OW-1:0];
         @(posedge i_clk);
         #1;
         i_ce         = 1'b1;
         i_fft_sync   = (k == 0);
         i_fft_result = {rb, ib};
         if (k == NB - 1) last_bin_cyc = cyc;
         if (push && k < NB) begin
            b.pw   = power_of(re, im);
            b.idx  = k;
            b.last = (k == NB - 1);
            exp_q.push_back(b);
         end
      end
      @(posedge i_clk);
      #1;
      i_ce       = 1'b0;
      i_fft_sync = 1'b0;
   endtask

   task automatic wait_drain();
      bit done = 1'b0;
      for (int i = 0; i < 400 && !done; i++) begin
         @(negedge i_clk);
         if (exp_q.size() == 0 && !bin_if.o_bin_valid) done = 1'b1;
      end
      if (!done) begin
         fail_now("drain_timeout");
         exp_q.delete();
      end
   endtask

   task automatic wait_valid_index(input int idx);
      bit done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge i_clk);
         if (bin_if.o_bin_valid && bin_if.o_bin_index == BW'(idx)) done = 1'b1;
      end
      if (!done) fail_now("valid_timeout");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int ov0, beats0;
      bin_if.i_bin_ready = 1'b1;
      #1;
      check("rst_valid", 64'(bin_if.o_bin_valid), 64'(0));
      check("rst_power", 64'(bin_if.o_bin_power), 64'(0));
      check("rst_index", 64'(bin_if.o_bin_index), 64'(0));
      check("rst_last", 64'(bin_if.o_frame_last), 64'(0));
      check("rst_overrun", 64'(o_overrun), 64'(0));
      check("rst_drop", 64'(o_drop_count), 64'(0));
      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      i_reset = 1'b0;

      rmode = 0;
      first_valid_cyc = -1;
      send_frame(FFT_SIZE, 0, 1'b1);
      wait_drain();
      check("first_valid_latency", 64'(first_valid_cyc), 64'(last_bin_cyc + 3));
      check("no_bubbles", 64'(xferl_cyc - xfer0_cyc), 64'(NB - 1));

      rmode = 1;
      send_frame(FFT_SIZE, 0, 1'b1);
      wait_drain();

      rmode = 2;
      send_frame(FFT_SIZE, 1, 1'b1);
      wait_drain();

      for (int f = 0; f < 4; f++) begin
         send_frame(FFT_SIZE, 2, 1'b1);
         wait_drain();
      end

      rmode = 3;
      ov0 = ovr_cycles;
      send_frame(FFT_SIZE, 2, 1'b1);
      wait_valid_index(0);
      send_frame(FFT_SIZE, 2, 1'b0);
      repeat (3) @(posedge i_clk);
      #1;
      check("readout_overrun_pulses", 64'(ovr_cycles - ov0), 64'(1));
      check("readout_drop_count", 64'(o_drop_count), 64'(1));
      rmode = 2;
      wait_drain();

      rmode = 0;
      beats0 = beats;
      for (int i = 0; i < 5; i++) begin
         @(posedge i_clk);
         #1;
         i_ce         = 1'b0;
         i_fft_sync   = 1'b1;
         i_fft_result = 36'($urandom);
      end
      @(posedge i_clk);
      #1;
      i_fft_sync = 1'b0;
      repeat (30) @(posedge i_clk);
      #1;
      check("sync_without_ce_beats", 64'(beats - beats0), 64'(0));
      check("sync_without_ce_valid", 64'(bin_if.o_bin_valid), 64'(0));
      ov0 = ovr_cycles;
      send_frame(4, 2, 1'b0);
      send_frame(FFT_SIZE, 2, 1'b1);
      wait_drain();
      check("capture_overrun_pulses", 64'(ovr_cycles - ov0), 64'(1));
      check("capture_drop_count", 64'(o_drop_count), 64'(2));

      rmode = 4;
      send_frame(FFT_SIZE, 2, 1'b1);
      wait_valid_index(5);
      #2;
      i_reset = 1'b1;
      #1;
      check("async_rst_valid", 64'(bin_if.o_bin_valid), 64'(0));
      check("async_rst_index", 64'(bin_if.o_bin_index), 64'(0));
      check("async_rst_drop", 64'(o_drop_count), 64'(0));
      check("async_rst_power", 64'(bin_if.o_bin_power), 64'(0));
      exp_q.delete();
      repeat (2) @(negedge i_clk);
      i_reset = 1'b0;
      rmode = 0;
      send_frame(FFT_SIZE, 0, 1'b1);
      wait_drain();
      check("post_reset_drop", 64'(o_drop_count), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
